// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus: instruction-memory read port plus the {pc, instr}
// valid/ready hand-off to decode. master = fetch unit, slave = memory/decode.
interface instr_fetch_unit_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  modport master (
    output instr_addr,
    input  instr_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_fault
  );

  modport slave (
    input  instr_addr,
    output instr_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: PC, instruction-memory read, fetch FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  instr_fetch_unit_if.master         bus
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_FAULT = 2'd2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   rd_q, wr_q;

  logic [31:0]     mem_pc    [FIFO_DEPTH];
  logic [31:0]     mem_instr [FIFO_DEPTH];

  logic            head_valid;
  logic            pop_raw;
  logic            pop;
  logic            fetch_push;
  logic            push;
  logic [31:0]     push_pc;
  logic [31:0]     push_instr;
  logic            push_fault;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            mem_fault [FIFO_DEPTH];
  logic            fault_pend_q;
  logic [31:0]     fault_pc_q;
  logic            misaligned;

  assign misaligned = redirect_pc[1:0] != 2'b00;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned) state_d = S_FAULT;
`endif
    end else begin
      case (state_q)
        S_RUN, S_HOLD: state_d = fetch_en ? S_RUN : S_HOLD;
`ifdef FETCH_MISALIGN_TRAP_EN
        S_FAULT:       state_d = S_FAULT;
`endif
        default:       state_d = S_RUN;
      endcase
    end
  end

  // Handshake / push selection; redirect voids both pop and push
  always_comb begin
    head_valid = cnt_q != '0;
    pop_raw    = head_valid && bus.out_ready;
    pop        = pop_raw && !redirect_valid;
    fetch_push = (state_q == S_RUN) && fetch_en && !redirect_valid &&
                 ((cnt_q < CW'(FIFO_DEPTH)) || pop_raw);
    push       = fetch_push;
    push_pc    = pc_q;
    push_instr = bus.instr_data;
    push_fault = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    // The trap entry goes into a just-flushed FIFO, so space is guaranteed.
    if ((state_q == S_FAULT) && fault_pend_q && !redirect_valid) begin
      push       = 1'b1;
      push_pc    = fault_pc_q;
      push_instr = NOP;
      push_fault = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
`endif
    end else if (redirect_valid) begin
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      pc_q  <= redirect_pc & ~32'h0000_0003;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_pend_q <= misaligned;
      fault_pc_q   <= redirect_pc;
`endif
    end else begin
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (pop)        rd_q <= rd_q + PW'(1);
      if (push)       wr_q <= wr_q + PW'(1);
      if (fetch_push) pc_q <= pc_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (push_fault) fault_pend_q <= 1'b0;
`endif
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (rst_n && !redirect_valid && push) begin
      mem_pc[wr_q]    <= push_pc;
      mem_instr[wr_q] <= push_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
      mem_fault[wr_q] <= push_fault;
`endif
    end
  end

  assign bus.instr_addr = pc_q;
  assign bus.out_valid  = head_valid;
  assign bus.out_pc     = head_valid ? mem_pc[rd_q]    : '0;
  assign bus.out_instr  = head_valid ? mem_instr[rd_q] : NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.out_fault  = head_valid ? mem_fault[rd_q] : 1'b0;
`else
  assign bus.out_fault  = 1'b0;
  logic unused_fault;
  assign unused_fault = push_fault;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front-end and initiator side of the instruction-memory read interface. Holds the PC and drives a word-aligned byte address to the instruction memory. Captures the combinationally returned instruction word into a small FIFO and presents {pc, instr} to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, which flush all in-flight entries.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
FIFO_DEPTH, 2, fetch buffer entries; power of two, 2..8.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
fetch_en  input  1  1 = fetching allowed; 0 = hold PC, no new pushes
instr_addr  output  32  byte address to instruction memory; always equals pc_q, bits [1:0] = 0
instr_data  input  32  instruction word returned combinationally for instr_addr
redirect_valid  input  1  1-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  input  32  redirect target byte address
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head
out_instr  output  32  head instruction word
out_pc  output  32  head instruction byte address
out_fault  output  1  head entry is a fetch fault (see Optional Feature); 0 otherwise

Behaviour:
- Reset (rst_n=0 at posedge): pc_q=RESET_PC, FIFO count=0, rd/wr pointers=0, state=RUN. Resulting outputs: out_valid=0, out_instr=32'h00000013, out_pc=0, out_fault=0, instr_addr=RESET_PC. Reset mid-operation discards all entries the same cycle.
- States:
  - RUN: fetching.
  - HOLD: entered when fetch_en=0; returns to RUN when fetch_en=1.
  - FAULT: only with the optional macro.
  - A redirect always returns the FSM to RUN, or to FAULT if misaligned.
- pop = out_valid & out_ready.
- push = state==RUN & fetch_en & !redirect_valid & (count<FIFO_DEPTH | pop).
  - Full plus simultaneous pop still pushes: sustained 1 instr/cycle at depth 2.
- On push: the entry {pc_q, instr_data, fault=0} is written and pc_q <= pc_q + 4.
  - Mod 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Latency: instruction at pc_q appears at out_* one cycle after the push edge. No combinational path from instr_data or out_ready to out_*.
- Redirect has priority over push and pop in the same cycle:
  - count <= 0, pointers reset, pc_q <= {redirect_pc[31:2], 2'b00}.
  - The head is not consumed even if out_ready=1; decode must treat that cycle's handshake as void.
  - First post-redirect entry is valid 2 cycles after the redirect edge (1 to fetch, 1 to present).
- Empty: out_valid=0, out_instr=32'h00000013 (NOP), out_pc/out_fault hold 0.
- fetch_en=0 does not block pops; the FIFO drains normally.
- count width = clog2(FIFO_DEPTH)+1. Never exceeds FIFO_DEPTH; never underflows (pop only when out_valid).

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 enters FAULT.
  - FIFO flushed.
  - One entry {pc=redirect_pc unmodified, instr=32'h00000013, fault=1} is pushed on the next cycle.
  - No further fetch; pc_q frozen.
  - FAULT is left only via reset or a new redirect.
- Undefined: FAULT state absent; low two bits of redirect_pc silently cleared; out_fault tied 0.

Test Plan:
1. Reset, fetch_en=1, out_ready=1, memory returns word=addr:
   - out_pc sequence 0x0,0x4,0x8… on consecutive cycles, first out_valid 1 cycle after reset release.
   - out_instr matches out_pc.
2. Back-pressure: out_ready=0 for 5 cycles.
   - count saturates at 2, pc_q stops at 0x8, out_pc holds 0x0.
   - Release out_ready: 0x0,0x4,0x8 delivered with no gap or duplicate.
3. Redirect to 0x40 while FIFO full and out_ready=1:
   - No pop that cycle, out_valid=0 next cycle.
   - Next out_pc=0x40, then 0x44.
4. RESET_PC=32'hFFFF_FFF8: out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
5. fetch_en=0 with 2 buffered entries, out_ready=1:
   - Both drain, then out_valid=0, instr_addr stable.
   - fetch_en=1 resumes at the next PC.
6. Redirect to 0x42:
   - With FETCH_MISALIGN_TRAP_EN: single entry out_pc=0x42, out_fault=1, out_instr=0x13, then out_valid=0 indefinitely; redirect to 0x80 recovers.
   - Without: fetch resumes at 0x40, out_fault=0.
